// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the instruction fetch stage: FSM states, NOP encoding
// and the default reset PC.
package fetch_stage_pkg;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        HALTED = 2'd1,
        FAULT  = 2'd2
    } state_t;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction memory bus between the fetch stage (master) and a combinational
// instruction memory (slave).
interface fetch_stage_if #(
    parameter int ADDRESS_WIDTH = 32,
    parameter int INSTR_WIDTH   = 32
);
    logic [ADDRESS_WIDTH-1:0] instr_addr;
    logic [INSTR_WIDTH-1:0]   instr_data;

    modport master (output instr_addr, input instr_data);
    modport slave  (input instr_addr, output instr_data);
endinterface

// File: rtl/fetch_stage_ifid_reg.sv
// IF/ID pipeline register: load captures a fetched word, clear drops the valid
// flag while leaving the payload untouched.
module ifid_reg
    import fetch_stage_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 32,
    parameter int INSTR_WIDTH   = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     load,
    input  logic                     clear,
    input  logic [INSTR_WIDTH-1:0]   fetch_instr,
    input  logic [ADDRESS_WIDTH-1:0] fetch_pc,
    output logic                     ifid_valid,
    output logic [INSTR_WIDTH-1:0]   ifid_instr,
    output logic [ADDRESS_WIDTH-1:0] ifid_pc,
    output logic [ADDRESS_WIDTH-1:0] ifid_pc_plus4
);

    always_ff @(posedge clk) begin
        if (rst) begin
            ifid_valid    <= 1'b0;
            ifid_instr    <= INSTR_WIDTH'(NOP_INSTR);
            ifid_pc       <= '0;
            ifid_pc_plus4 <= '0;
        end else if (clear) begin
            ifid_valid <= 1'b0;
        end else if (load) begin
            ifid_valid    <= 1'b1;
            ifid_instr    <= fetch_instr;
            ifid_pc       <= fetch_pc;
            ifid_pc_plus4 <= fetch_pc + ADDRESS_WIDTH'(4);
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, RUN/HALTED/FAULT control and the IF/ID
// register feeding decode.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter int                       ADDRESS_WIDTH = 32,
    parameter int                       INSTR_WIDTH   = 32,
    parameter logic [ADDRESS_WIDTH-1:0] RESET_PC      = ADDRESS_WIDTH'(DEFAULT_RESET_PC)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     stall,
    input  logic                     redirect,
    input  logic [ADDRESS_WIDTH-1:0] redirect_pc,
    input  logic                     halt_req,
    input  logic                     resume,
    fetch_stage_if.master            bus,
    output logic                     ifid_valid,
    output logic [INSTR_WIDTH-1:0]   ifid_instr,
    output logic [ADDRESS_WIDTH-1:0] ifid_pc,
    output logic [ADDRESS_WIDTH-1:0] ifid_pc_plus4,
    output logic                     fault,
    output logic                     halted
);

    state_t                   state;
    logic [ADDRESS_WIDTH-1:0] pc_q;
    logic                     fetch_en;
    logic                     squash;
    logic                     target_aligned;

    assign bus.instr_addr = pc_q;
    assign target_aligned = (redirect_pc[1:0] == 2'b00);

    // Outside RUN, and on any redirect or halt, whatever sits in IF/ID is dead.
    always_comb begin
        fetch_en = 1'b0;
        squash   = 1'b0;
        if (state != RUN) begin
            squash = 1'b1;
        end else if (redirect || halt_req) begin
            squash = 1'b1;
        end else if (!stall) begin
            fetch_en = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= RUN;
            pc_q   <= RESET_PC;
            fault  <= 1'b0;
            halted <= 1'b0;
        end else begin
            unique case (state)
                RUN: begin
                    if (redirect) begin
                        if (target_aligned) begin
                            pc_q <= redirect_pc;
                        end else begin
                            state <= FAULT;
                            fault <= 1'b1;
                        end
                    end else if (halt_req) begin
                        state  <= HALTED;
                        halted <= 1'b1;
                    end else if (!stall) begin
                        pc_q <= pc_q + ADDRESS_WIDTH'(4);
                    end
                end
                // Resume only re-arms fetch; the held PC is fetched next edge.
                HALTED: begin
                    if (resume) begin
                        state  <= RUN;
                        halted <= 1'b0;
                    end
                end
                FAULT: begin
                    state <= FAULT;
                end
                default: begin
                    state <= RUN;
                end
            endcase
        end
    end

    ifid_reg #(
        .ADDRESS_WIDTH(ADDRESS_WIDTH),
        .INSTR_WIDTH  (INSTR_WIDTH)
    ) u_ifid (
        .clk          (clk),
        .rst          (rst),
        .load         (fetch_en),
        .clear        (squash),
        .fetch_instr  (bus.instr_data),
        .fetch_pc     (pc_q),
        .ifid_valid   (ifid_valid),
        .ifid_instr   (ifid_instr),
        .ifid_pc      (ifid_pc),
        .ifid_pc_plus4(ifid_pc_plus4)
    );

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios plus randomized control inputs
// checked against a cycle-level behavioural model of the fetch stage.
module tb_fetch_stage;

    localparam int AW = 32;
    localparam int IW = 32;

    logic          clk = 1'b0;
    logic          rst, stall, redirect, halt_req, resume;
    logic [AW-1:0] redirect_pc;
    logic          ifid_valid, fault, halted;
    logic [IW-1:0] ifid_instr;
    logic [AW-1:0] ifid_pc, ifid_pc_plus4;

    logic          rst2;
    logic          ifid_valid2, fault2, halted2;
    logic [IW-1:0] ifid_instr2;
    logic [AW-1:0] ifid_pc2, ifid_pc_plus42;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    function automatic logic [IW-1:0] mem_word(input logic [AW-1:0] a);
        if (a < 32'd16) return (a / 4 + 1) * 32'h11;
        return (a * 32'h9E37_79B1) ^ 32'h0000_5A5A;
    endfunction

    fetch_stage_if #(.ADDRESS_WIDTH(AW), .INSTR_WIDTH(IW)) bus ();
    fetch_stage_if #(.ADDRESS_WIDTH(AW), .INSTR_WIDTH(IW)) bus2 ();
    assign bus.instr_data  = mem_word(bus.instr_addr);
    assign bus2.instr_data = mem_word(bus2.instr_addr);

    fetch_stage #(.ADDRESS_WIDTH(AW), .INSTR_WIDTH(IW), .RESET_PC(32'h0)) dut (
        .clk(clk), .rst(rst), .stall(stall), .redirect(redirect),
        .redirect_pc(redirect_pc), .halt_req(halt_req), .resume(resume),
        .bus(bus), .ifid_valid(ifid_valid), .ifid_instr(ifid_instr),
        .ifid_pc(ifid_pc), .ifid_pc_plus4(ifid_pc_plus4),
        .fault(fault), .halted(halted)
    );

    fetch_stage #(.ADDRESS_WIDTH(AW), .INSTR_WIDTH(IW), .RESET_PC(32'hFFFF_FFFC)) dut_wrap (
        .clk(clk), .rst(rst2), .stall(1'b0), .redirect(1'b0),
        .redirect_pc(32'h0), .halt_req(1'b0), .resume(1'b0),
        .bus(bus2), .ifid_valid(ifid_valid2), .ifid_instr(ifid_instr2),
        .ifid_pc(ifid_pc2), .ifid_pc_plus4(ifid_pc_plus42),
        .fault(fault2), .halted(halted2)
    );

    // Behavioural model of dut (RESET_PC = 0).
    localparam int M_RUN = 0, M_HALT = 1, M_FAULT = 2;
    int            m_mode;
    logic [AW-1:0] m_pc, m_ipc, m_ip4;
    logic [IW-1:0] m_ins;
    logic          m_v, m_f;

    task automatic model_edge();
        if (rst) begin
            m_mode = M_RUN; m_pc = 0; m_v = 0; m_f = 0;
            m_ins = 32'h13; m_ipc = 0; m_ip4 = 0;
        end else if (m_mode == M_RUN) begin
            if (redirect) begin
                m_v = 0;
                if (redirect_pc % 4 == 0) m_pc = redirect_pc;
                else begin m_mode = M_FAULT; m_f = 1; end
            end else if (halt_req) begin
                m_mode = M_HALT; m_v = 0;
            end else if (!stall) begin
                m_ins = mem_word(m_pc); m_ipc = m_pc; m_ip4 = m_pc + 4;
                m_v = 1; m_pc = m_pc + 4;
            end
        end else if (m_mode == M_HALT) begin
            if (resume) m_mode = M_RUN;
        end
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        stall = 0; redirect = 0; redirect_pc = 0; halt_req = 0; resume = 0; rst = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1;
        tick();
        rst = 0;
    endtask

    task automatic test_reset();
        stall = 1; redirect = 1; redirect_pc = 32'h40; halt_req = 1; resume = 0; rst = 1;
        tick();
        rst = 0; stall = 0; redirect = 0; halt_req = 0;
        total++; if (bus.instr_addr !== 32'h0) begin bad++; $display("FAIL reset_pc got=%h exp=%h", bus.instr_addr, 32'h0); end
        total++; if (ifid_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", ifid_valid); end
        total++; if (ifid_instr !== 32'h13) begin bad++; $display("FAIL reset_nop got=%h exp=00000013", ifid_instr); end
        total++; if (ifid_pc !== 0 || ifid_pc_plus4 !== 0) begin bad++; $display("FAIL reset_ifid_pc got=%h/%h exp=0/0", ifid_pc, ifid_pc_plus4); end
        total++; if (fault !== 0 || halted !== 0) begin bad++; $display("FAIL reset_flags got=%b%b exp=00", fault, halted); end
    endtask

    task automatic test_sequential();
        logic [IW-1:0] exp_w [4] = '{32'h11, 32'h22, 32'h33, 32'h44};
        do_reset();
        for (int i = 0; i < 4; i++) begin
            tick();
            total++;
            if (ifid_pc !== 32'(i * 4) || ifid_instr !== exp_w[i] || ifid_valid !== 1'b1 ||
                ifid_pc_plus4 !== 32'(i * 4 + 4)) begin
                bad++;
                $display("FAIL seq_fetch%0d got pc=%h ins=%h v=%b p4=%h exp pc=%h ins=%h v=1 p4=%h",
                         i, ifid_pc, ifid_instr, ifid_valid, ifid_pc_plus4, i * 4, exp_w[i], i * 4 + 4);
            end
        end
    endtask

    task automatic test_stall();
        do_reset();
        tick(); tick();
        stall = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if (ifid_pc !== 32'h4 || ifid_instr !== 32'h22 || ifid_valid !== 1'b1 || bus.instr_addr !== 32'h8) begin
                bad++;
                $display("FAIL stall_hold%0d got pc=%h ins=%h v=%b addr=%h exp pc=4 ins=22 v=1 addr=8",
                         i, ifid_pc, ifid_instr, ifid_valid, bus.instr_addr);
            end
        end
        stall = 0;
        tick();
        total++; if (ifid_pc !== 32'h8 || ifid_instr !== 32'h33) begin bad++; $display("FAIL stall_release got pc=%h ins=%h exp pc=8 ins=33", ifid_pc, ifid_instr); end
    endtask

    task automatic test_stall_redirect();
        stall = 1; redirect = 1; redirect_pc = 32'h100;
        tick();
        stall = 0; redirect = 0;
        total++; if (ifid_valid !== 1'b0 || bus.instr_addr !== 32'h100) begin bad++; $display("FAIL stall_redirect got v=%b addr=%h exp v=0 addr=100", ifid_valid, bus.instr_addr); end
        tick();
        total++; if (ifid_pc !== 32'h100 || ifid_valid !== 1'b1 || ifid_instr !== mem_word(32'h100)) begin bad++; $display("FAIL redirect_fetch got pc=%h v=%b ins=%h exp pc=100 v=1 ins=%h", ifid_pc, ifid_valid, ifid_instr, mem_word(32'h100)); end
    endtask

    task automatic test_fault();
        logic [AW-1:0] held;
        held = bus.instr_addr;
        redirect = 1; redirect_pc = 32'h102;
        tick();
        redirect = 0;
        total++; if (fault !== 1'b1 || ifid_valid !== 1'b0 || bus.instr_addr !== held) begin bad++; $display("FAIL fault_enter got f=%b v=%b addr=%h exp f=1 v=0 addr=%h", fault, ifid_valid, bus.instr_addr, held); end
        redirect = 1; redirect_pc = 32'h200;
        tick(); redirect = 0; halt_req = 1; tick(); halt_req = 0; resume = 1; tick(); resume = 0; tick();
        total++; if (fault !== 1'b1 || ifid_valid !== 1'b0 || bus.instr_addr !== held || halted !== 1'b0) begin bad++; $display("FAIL fault_sticky got f=%b v=%b addr=%h h=%b exp f=1 v=0 addr=%h h=0", fault, ifid_valid, bus.instr_addr, halted, held); end
        do_reset();
        total++; if (fault !== 1'b0 || bus.instr_addr !== 32'h0) begin bad++; $display("FAIL fault_reset got f=%b addr=%h exp f=0 addr=0", fault, bus.instr_addr); end
    endtask

    task automatic test_halt();
        do_reset();
        for (int i = 0; i < 8; i++) tick();
        halt_req = 1;
        tick();
        halt_req = 0;
        total++; if (halted !== 1'b1 || ifid_valid !== 1'b0 || bus.instr_addr !== 32'h20) begin bad++; $display("FAIL halt_enter got h=%b v=%b addr=%h exp h=1 v=0 addr=20", halted, ifid_valid, bus.instr_addr); end
        redirect = 1; redirect_pc = 32'h300;
        tick();
        redirect = 0;
        total++; if (halted !== 1'b1 || bus.instr_addr !== 32'h20) begin bad++; $display("FAIL halt_redirect got h=%b addr=%h exp h=1 addr=20", halted, bus.instr_addr); end
        resume = 1;
        tick();
        resume = 0;
        total++; if (halted !== 1'b0 || ifid_valid !== 1'b0 || bus.instr_addr !== 32'h20) begin bad++; $display("FAIL resume_edge got h=%b v=%b addr=%h exp h=0 v=0 addr=20", halted, ifid_valid, bus.instr_addr); end
        tick();
        total++; if (ifid_pc !== 32'h20 || ifid_valid !== 1'b1 || bus.instr_addr !== 32'h24) begin bad++; $display("FAIL resume_fetch got pc=%h v=%b addr=%h exp pc=20 v=1 addr=24", ifid_pc, ifid_valid, bus.instr_addr); end
    endtask

    task automatic test_wrap();
        rst2 = 1;
        tick();
        rst2 = 0;
        total++; if (bus2.instr_addr !== 32'hFFFF_FFFC) begin bad++; $display("FAIL wrap_reset got addr=%h exp fffffffc", bus2.instr_addr); end
        tick();
        total++; if (bus2.instr_addr !== 32'h0 || ifid_pc2 !== 32'hFFFF_FFFC || ifid_pc_plus42 !== 32'h0 || ifid_valid2 !== 1'b1) begin bad++; $display("FAIL wrap_second got addr=%h pc=%h p4=%h v=%b exp addr=0 pc=fffffffc p4=0 v=1", bus2.instr_addr, ifid_pc2, ifid_pc_plus42, ifid_valid2); end
    endtask

    task automatic test_random();
        int errs_here;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            stall    = ($urandom_range(0, 3) == 0);
            redirect = ($urandom_range(0, 9) == 0);
            redirect_pc = {16'($urandom), 14'($urandom), 2'b00};
            if ($urandom_range(0, 15) == 0) redirect_pc[1:0] = 2'($urandom_range(1, 3));
            halt_req = ($urandom_range(0, 19) == 0);
            resume   = ($urandom_range(0, 2) == 0);
            rst      = ($urandom_range(0, 49) == 0) || (m_mode == M_FAULT && $urandom_range(0, 7) == 0);
            tick();
            errs_here = 0;
            total++;
            if (bus.instr_addr !== m_pc || ifid_valid !== m_v || fault !== m_f ||
                halted !== (m_mode == M_HALT)) begin
                bad++; errs_here++;
                $display("FAIL rand_ctrl c=%0d got addr=%h v=%b f=%b h=%b exp addr=%h v=%b f=%b h=%b",
                         c, bus.instr_addr, ifid_valid, fault, halted, m_pc, m_v, m_f, m_mode == M_HALT);
            end
            total++;
            if (ifid_instr !== m_ins || ifid_pc !== m_ipc || ifid_pc_plus4 !== m_ip4) begin
                bad++; errs_here++;
                $display("FAIL rand_ifid c=%0d got ins=%h pc=%h p4=%h exp ins=%h pc=%h p4=%h",
                         c, ifid_instr, ifid_pc, ifid_pc_plus4, m_ins, m_ipc, m_ip4);
            end
            if (errs_here != 0) break;
        end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        rst2 = 1;
        m_mode = M_RUN; m_pc = 0; m_v = 0; m_f = 0; m_ins = 32'h13; m_ipc = 0; m_ip4 = 0;
        test_reset();
        test_sequential();
        test_stall();
        test_stall_redirect();
        test_fault();
        test_halt();
        test_wrap();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
